pipeline_rr_arbiter: RTL and testbench
======================================

# pipeline_rr_arbiter

Shares one registered valid/ready pipeline stage among PORTS upstream requesters. Round-robin arbitration is done per transaction, not per beat. A requester that wins keeps the stage until it presents a beat with i_last=1. The block sits in front of a single downstream stage, so several producers can feed one shared consumer without interleaving their multi-beat transactions.

## Interface
- PORTS, 4: number of requesters; legal range 2..16.
- VALUE_BITS, 8: payload width per beat.
- PORT_BITS, $clog2(PORTS): width of the port index. Derived; do not override.
- clock  input  1  rising-edge clock; the block has one clock domain.
- reset  input  1  synchronous, active-high reset.
- i_value  input  PORTS*VALUE_BITS  per-port payload; port p occupies [p*VALUE_BITS +: VALUE_BITS].
- i_last  input  PORTS  per-port flag marking the final beat of a transaction.
- i_valid  input  PORTS  per-port valid.
- o_ready  output  PORTS  per-port ready; at most one bit is set in any cycle.
- o_value  output  VALUE_BITS  registered payload.
- o_last  output  1  registered last flag.
- o_port  output  PORT_BITS  registered index of the source port.
- o_valid  output  1  registered valid.
- i_ready  input  1  downstream ready.

## Operation
- Reset (sampled on the clock edge while reset=1):
  - Registered outputs: o_value=0, o_last=0, o_port=0, o_valid=0.
  - Control: state=ARB_IDLE, priority pointer ptr=0, lock_port=0.
- Stage ready: stage_ready = ~o_valid | i_ready.
- A beat on port p is accepted when i_valid[p] & o_ready[p].
- State ARB_IDLE:
  - Winner g = first port with i_valid set, scanning ptr, ptr+1, … mod PORTS.
  - o_ready[g] = stage_ready. All other o_ready bits = 0.
  - If no port is valid, o_ready = 0.
  - Accept with i_last[g]=1: stay in ARB_IDLE; ptr <= (g+1) mod PORTS.
  - Accept with i_last[g]=0: go to ARB_LOCK; lock_port <= g. ptr is unchanged.
- State ARB_LOCK:
  - o_ready[lock_port] = stage_ready. All other o_ready bits = 0, even if those ports are valid.
  - If the locked port deasserts i_valid, the stage receives a bubble and the block stays in ARB_LOCK. There is no timeout.
  - Accept with i_last=1: go to ARB_IDLE; ptr <= (lock_port+1) mod PORTS.
- Output register, updated when stage_ready:
  - o_valid <= (some beat is accepted).
  - On accept: o_value, o_last and o_port are loaded from the granted port.
  - When no beat is accepted, the payload registers hold their previous value.
- o_ready may depend combinationally on i_valid and i_ready. No input may depend combinationally on any o_ready.
- Wrap-around: ptr is taken mod PORTS for any PORTS value, including non-powers of two. ptr and lock_port never exceed PORTS-1.

## Timing
- Latency: an accepted beat appears on o_valid one cycle later.
- Throughput: one beat per cycle while i_ready=1.
- Back-to-back transactions from different ports need no idle cycle.
- Stall: while o_valid=1 and i_ready=0:
  - o_value, o_last, o_port and o_valid hold.
  - All o_ready bits = 0.
  - state and ptr hold.
- Simultaneous drain and fill: with o_valid=1 and i_ready=1, a new beat is accepted in the same cycle.
- Reset mid-transaction: the next cycle is ARB_IDLE with o_valid=0. The partial transaction is dropped, and the requester must restart it.
- A single-beat transaction (i_last=1 on its first beat) never enters ARB_LOCK.

## Structure
- Shared package pipeline_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;
  - a function that computes the port-index width from PORTS.
- One sub-module, pipeline_rr_pick:
  - Purely combinational rotating-priority picker.
  - Inputs: PORTS-bit request vector, ptr.
  - Outputs: one-hot grant, grant index, any_valid.
  - The arbiter instantiates it once. The FSM, pointer and output register stay in pipeline_rr_arbiter.

## Test plan
- Reset, then i_valid=4'b1111, all i_last=1, i_ready=1.
  - Expect o_port sequence 0,1,2,3,0.
  - o_valid rises one cycle after the first accept.
- Port 2 sends 3 beats (0xA0, 0xA1, 0xA2 with last) while ports 0 and 3 are also valid.
  - Expect all three beats from port 2 contiguous, with o_port=2.
  - Next grant goes to port 3, then port 0.
- Hold i_ready=0 for 4 cycles while o_valid=1 and o_value=0x5C.
  - Outputs stay stable.
  - o_ready=0 on every port.
  - Nothing is lost after release.
- In ARB_LOCK on port 1, drop i_valid[1] for 2 cycles while port 0 is valid.
  - o_valid=0 bubbles.
  - Port 0 is not granted until port 1 sends its last beat.
- Assert reset for 1 cycle mid-transaction.
  - Next cycle: o_valid=0, state ARB_IDLE, ptr=0.
  - The next grant follows ptr=0 order.
- PORTS=3: port 2 completes a transaction.
  - ptr wraps to 0, and port 0 wins over port 1 when both are valid.

Source files
------------

// File: rtl/pipeline_arb_pkg.sv
// Shared types and helpers for the pipelined round-robin arbiter.
package pipeline_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    // Port-index width; a single bit is kept even for degenerate port counts.
    function automatic int port_bits_f(input int ports);
        return (ports > 2) ? $clog2(ports) : 1;
    endfunction

endpackage

// File: rtl/pipeline_rr_pick.sv
// Rotating-priority picker: the first requesting port at or after i_ptr
// (modulo PORTS) wins.
module pipeline_rr_pick
    import pipeline_arb_pkg::*;
#(
    parameter  int PORTS     = 4,
    localparam int PORT_BITS = port_bits_f(PORTS)
) (
    input  logic [PORTS-1:0]     i_req,
    input  logic [PORT_BITS-1:0] i_ptr,
    output logic [PORTS-1:0]     o_grant,
    output logic [PORT_BITS-1:0] o_idx,
    output logic                 o_any
);

    int w_dist;
    int w_best;

    // Pick the requester with the smallest rotated distance from the pointer.
    always_comb begin
        w_best  = PORTS;
        w_dist  = 0;
        o_idx   = '0;
        o_any   = 1'b0;
        o_grant = '0;
        for (int p = 0; p < PORTS; p++) begin
            w_dist = (p >= int'(i_ptr)) ? (p - int'(i_ptr)) : (p + PORTS - int'(i_ptr));
            if (i_req[p] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = PORT_BITS'(p);
                o_any  = 1'b1;
            end else begin
                w_best = w_best;
            end
        end
        for (int p = 0; p < PORTS; p++) begin
            o_grant[p] = o_any && (o_idx == PORT_BITS'(p));
        end
    end

endmodule

// File: rtl/pipeline_rr_arbiter.sv
// Per-transaction round-robin arbiter feeding one registered valid/ready stage;
// a winner keeps the stage until it sends a beat with i_last set.
module pipeline_rr_arbiter
    import pipeline_arb_pkg::*;
#(
    parameter  int PORTS      = 4,
    parameter  int VALUE_BITS = 8,
    localparam int PORT_BITS  = port_bits_f(PORTS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [PORTS*VALUE_BITS-1:0] i_value,
    input  logic [PORTS-1:0]            i_last,
    input  logic [PORTS-1:0]            i_valid,
    output logic [PORTS-1:0]            o_ready,
    output logic [VALUE_BITS-1:0]       o_value,
    output logic                        o_last,
    output logic [PORT_BITS-1:0]        o_port,
    output logic                        o_valid,
    input  logic                        i_ready
);

    arb_state_t             r_state;
    logic [PORT_BITS-1:0]   r_ptr;
    logic [PORT_BITS-1:0]   r_lock;
    logic [VALUE_BITS-1:0]  r_value;
    logic                   r_last;
    logic [PORT_BITS-1:0]   r_port;
    logic                   r_valid;

    logic                   w_stage_ready;
    logic [PORTS-1:0]       w_grant;
    logic [PORT_BITS-1:0]   w_pick_idx;
    logic                   w_any;
    logic [PORT_BITS-1:0]   w_sel_idx;
    logic [VALUE_BITS-1:0]  w_sel_value;
    logic                   w_sel_last;
    logic [PORTS-1:0]       w_ready;
    logic                   w_accept;
    logic [PORT_BITS-1:0]   w_next_ptr;

    pipeline_rr_pick #(
        .PORTS (PORTS)
    ) u_pick (
        .i_req   (i_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_any)
    );

    // Grant selection, payload mux and pointer advance.
    always_comb begin
        w_stage_ready = ~r_valid | i_ready;
        w_sel_idx     = (r_state == ARB_LOCK) ? r_lock : w_pick_idx;
        w_ready       = '0;
        w_sel_value   = '0;
        w_sel_last    = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            // A locked port owns the stage even while it is not valid (bubbles).
            w_ready[p] = w_stage_ready &&
                         ((r_state == ARB_LOCK) ? (r_lock == PORT_BITS'(p)) : (w_any && w_grant[p]));
            if (w_sel_idx == PORT_BITS'(p)) begin
                w_sel_value = i_value[p*VALUE_BITS +: VALUE_BITS];
                w_sel_last  = i_last[p];
            end else begin
                w_sel_value = w_sel_value;
            end
        end
        w_accept   = |(w_ready & i_valid);
        w_next_ptr = (w_sel_idx == PORT_BITS'(PORTS-1)) ? '0 : (w_sel_idx + PORT_BITS'(1));
    end

    // Arbitration FSM, priority pointer and output stage register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_ptr   <= '0;
            r_lock  <= '0;
            r_value <= '0;
            r_last  <= 1'b0;
            r_port  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_stage_ready) begin
                r_valid <= w_accept;
                if (w_accept) begin
                    r_value <= w_sel_value;
                    r_last  <= w_sel_last;
                    r_port  <= w_sel_idx;
                end
            end
            case (r_state)
                ARB_IDLE: begin
                    if (w_accept && w_sel_last) begin
                        r_ptr <= w_next_ptr;
                    end else if (w_accept) begin
                        r_state <= ARB_LOCK;
                        r_lock  <= w_sel_idx;
                    end
                end
                ARB_LOCK: begin
                    if (w_accept && w_sel_last) begin
                        r_state <= ARB_IDLE;
                        r_ptr   <= w_next_ptr;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign o_ready = w_ready;
    assign o_value = r_value;
    assign o_last  = r_last;
    assign o_port  = r_port;
    assign o_valid = r_valid;

endmodule

// File: tb/tb_pipeline_rr_arbiter.sv
// Randomised scoreboard bench for pipeline_rr_arbiter with a transaction-level
// reference model, plus a short wrap-around run on a 3-port instance.
module tb_pipeline_rr_arbiter;

    localparam int P  = 4;
    localparam int VB = 8;
    localparam int PB = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic [P*VB-1:0] i_value;
    logic [P-1:0]    i_last;
    logic [P-1:0]    i_valid;
    logic [P-1:0]    o_ready;
    logic [VB-1:0]   o_value;
    logic            o_last;
    logic [PB-1:0]   o_port;
    logic            o_valid;
    logic            i_ready;

    logic            b_reset;
    logic [3*VB-1:0] b_value;
    logic [2:0]      b_last;
    logic [2:0]      b_valid;
    logic [2:0]      b_oready;
    logic [VB-1:0]   b_ovalue;
    logic            b_olast;
    logic [1:0]      b_oport;
    logic            b_ovalid;
    logic            b_iready;

    always #5 clock = ~clock;

    pipeline_rr_arbiter #(.PORTS(P), .VALUE_BITS(VB)) dut (
        .clock(clock), .reset(reset), .i_value(i_value), .i_last(i_last),
        .i_valid(i_valid), .o_ready(o_ready), .o_value(o_value), .o_last(o_last),
        .o_port(o_port), .o_valid(o_valid), .i_ready(i_ready)
    );

    pipeline_rr_arbiter #(.PORTS(3), .VALUE_BITS(VB)) dut3 (
        .clock(clock), .reset(b_reset), .i_value(b_value), .i_last(b_last),
        .i_valid(b_valid), .o_ready(b_oready), .o_value(b_ovalue), .o_last(b_olast),
        .o_port(b_oport), .o_valid(b_ovalid), .i_ready(b_iready)
    );

    typedef struct {
        logic [7:0] v;
        logic       l;
        int         p;
    } beat_t;

    beat_t      q[$];
    int         checks = 0;
    int         passes = 0;

    // Reference model: requester generators plus arbitration state.
    int         rem[P];
    logic [7:0] val[P];
    bit         m_lock;
    int         m_lockp;
    int         m_ptr;
    bit         m_ovalid;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic new_txn(input int p);
        rem[p] = $urandom_range(4, 1);
        val[p] = 8'($urandom);
    endtask

    // vmode: 0 random, 1 all valid, 2 none valid; rmode: 0 random, 1 ready, 2 stalled
    task automatic step(input bit rst, input int vmode, input int rmode);
        int         g;
        bit         sr;
        bit         acc;
        logic [P-1:0] exp_r;
        @(posedge clock);
        #1;
        reset = rst;
        for (int p = 0; p < P; p++) begin
            i_valid[p] = (vmode == 1) ? 1'b1 : (vmode == 2) ? 1'b0 : ($urandom_range(9, 0) < 7);
            i_last[p]  = (rem[p] == 1);
            i_value[p*VB +: VB] = val[p];
        end
        i_ready = (rmode == 1) ? 1'b1 : (rmode == 2) ? 1'b0 : ($urandom_range(3, 0) != 0);
        @(negedge clock);
        if (rst) begin
            m_lock   = 1'b0;
            m_ptr    = 0;
            m_ovalid = 1'b0;
            q.delete();
            for (int p = 0; p < P; p++) new_txn(p);
        end else begin
            sr    = !m_ovalid || i_ready;
            g     = -1;
            exp_r = '0;
            if (m_lock) begin
                g = m_lockp;
            end else begin
                for (int k = 0; k < P; k++) begin
                    int c;
                    c = (m_ptr + k) % P;
                    if (g < 0 && i_valid[c]) g = c;
                end
            end
            if (g >= 0 && sr) exp_r[g] = 1'b1;
            chk("o_ready", 32'(o_ready), 32'(exp_r));
            chk("o_valid", 32'(o_valid), 32'(m_ovalid));
            acc = (g >= 0) && sr && i_valid[g];
            if (acc) begin
                q.push_back('{v: val[g], l: (rem[g] == 1), p: g});
                if (rem[g] == 1) begin
                    m_lock = 1'b0;
                    m_ptr  = (g + 1) % P;
                    new_txn(g);
                end else begin
                    m_lock  = 1'b1;
                    m_lockp = g;
                    rem[g]  = rem[g] - 1;
                    val[g]  = val[g] + 8'd1;
                end
            end
            if (sr) m_ovalid = acc;
        end
    endtask

    // Monitor: every beat taken downstream must match the scoreboard head.
    always @(negedge clock) begin
        if (!reset && o_valid && i_ready) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_beat: got port %0d value %0h expected none", o_port, o_value);
            end else begin
                beat_t e;
                e = q.pop_front();
                chk("beat_value", 32'(o_value), 32'(e.v));
                chk("beat_last", 32'(o_last), 32'(e.l));
                chk("beat_port", 32'(o_port), 32'(e.p));
            end
        end
    end

    logic [2:0] exp3_ready[4];
    int         exp3_port[3];

    initial begin
        reset   = 1'b1;
        i_valid = '0;
        i_last  = '0;
        i_value = '0;
        i_ready = 1'b0;
        b_reset = 1'b1;
        b_value = '0;
        b_last  = '0;
        b_valid = '0;
        b_iready = 1'b0;
        for (int p = 0; p < P; p++) new_txn(p);

        step(1'b1, 2, 1);
        step(1'b1, 2, 1);
        chk("reset_o_value", 32'(o_value), 32'd0);
        chk("reset_o_last", 32'(o_last), 32'd0);
        chk("reset_o_port", 32'(o_port), 32'd0);

        // All ports valid with single-beat transactions: pure rotation.
        for (int p = 0; p < P; p++) rem[p] = 1;
        for (int n = 0; n < 5; n++) step(1'b0, 1, 1);

        for (int n = 0; n < 300; n++) step(1'b0, 0, 0);
        for (int n = 0; n < 4; n++) step(1'b0, 0, 2);
        for (int n = 0; n < 20; n++) step(1'b0, 0, 0);
        step(1'b1, 0, 0);
        for (int n = 0; n < 300; n++) step(1'b0, 0, 0);
        for (int n = 0; n < 10; n++) step(1'b0, 2, 1);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        // 3-port instance: pointer must wrap from 2 back to 0.
        exp3_ready = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp3_port  = '{0, 1, 2};
        @(posedge clock);
        #1;
        b_reset  = 1'b0;
        b_valid  = 3'b111;
        b_last   = 3'b111;
        b_iready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("p3_ready", 32'(b_oready), 32'(exp3_ready[k]));
            if (k > 0) chk("p3_port", 32'(b_oport), 32'(exp3_port[k-1]));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
